// File: rtl/fetch_queue.sv
// fetch_queue: valid/ready FIFO of fetch packets between fetch and decode.
// Each entry holds a full packet (per-slot valid, PC, BTB sideband, exception).
// A packet with an all-zero slot mask completes its handshake but is dropped.
// Flush empties the queue on the next edge and overrides any push/pop.
module fetch_queue #(
  parameter int FETCH_W = 4,
  parameter int DEPTH   = 8,
  parameter int EXCP_W  = 5
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_flush,
  input  logic                             i_in_valid,
  output logic                             o_in_ready,
  input  logic [FETCH_W-1:0]               i_in_slot_valid,
  input  logic [FETCH_W-1:0][31:0]         i_in_pc,
  input  logic [FETCH_W-1:0]               i_in_hit,
  input  logic [FETCH_W-1:0]               i_in_predict,
  input  logic [FETCH_W-1:0][31:0]         i_in_target,
  input  logic [FETCH_W-1:0]               i_in_has_excp,
  input  logic [FETCH_W-1:0][EXCP_W-1:0]   i_in_excp_code,
  output logic                             o_out_valid,
  input  logic                             i_out_ready,
  output logic [FETCH_W-1:0]               o_out_slot_valid,
  output logic [FETCH_W-1:0][31:0]         o_out_pc,
  output logic [FETCH_W-1:0]               o_out_hit,
  output logic [FETCH_W-1:0]               o_out_predict,
  output logic [FETCH_W-1:0][31:0]         o_out_target,
  output logic [FETCH_W-1:0]               o_out_has_excp,
  output logic [FETCH_W-1:0][EXCP_W-1:0]   o_out_excp_code,
  output logic [$clog2(DEPTH):0]           o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [FETCH_W-1:0]             slot_valid;
    logic [FETCH_W-1:0][31:0]       pc;
    logic [FETCH_W-1:0]             hit;
    logic [FETCH_W-1:0]             predict;
    logic [FETCH_W-1:0][31:0]       target;
    logic [FETCH_W-1:0]             has_excp;
    logic [FETCH_W-1:0][EXCP_W-1:0] excp_code;
  } entry_t;

  entry_t             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;

  logic   w_push;
  logic   w_pop;
  entry_t w_in_entry;
  entry_t w_head_entry;

  // Handshakes depend only on registered occupancy, never on out_ready.
  assign o_in_ready  = (r_count != CNT_W'(DEPTH));
  assign o_out_valid = (r_count != {CNT_W{1'b0}});
  assign o_count     = r_count;

  // Empty slot masks complete the handshake but are not stored.
  assign w_push = i_in_valid & o_in_ready & (|i_in_slot_valid);
  assign w_pop  = o_out_valid & i_out_ready;

  assign w_in_entry = '{
    slot_valid: i_in_slot_valid,
    pc:         i_in_pc,
    hit:        i_in_hit,
    predict:    i_in_predict,
    target:     i_in_target,
    has_excp:   i_in_has_excp,
    excp_code:  i_in_excp_code
  };

  assign w_head_entry = r_mem[r_head];

  // Pointer and occupancy update; flush wins over push/pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= {PTR_W{1'b0}};
      r_tail  <= {PTR_W{1'b0}};
      r_count <= {CNT_W{1'b0}};
    end else if (i_flush) begin
      r_head  <= {PTR_W{1'b0}};
      r_tail  <= {PTR_W{1'b0}};
      r_count <= {CNT_W{1'b0}};
    end else begin
      // Power-of-two depth: natural overflow wraps DEPTH-1 to 0.
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)  r_head <= r_head + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Packet storage: cleared on reset, written at the tail on push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push && !i_flush) begin
      r_mem[r_tail] <= w_in_entry;
    end
  end

  // Head packet fields; slot mask is forced to zero when the queue is empty.
  always_comb begin
    o_out_pc        = w_head_entry.pc;
    o_out_hit       = w_head_entry.hit;
    o_out_predict   = w_head_entry.predict;
    o_out_target    = w_head_entry.target;
    o_out_has_excp  = w_head_entry.has_excp;
    o_out_excp_code = w_head_entry.excp_code;
    if (o_out_valid) begin
      o_out_slot_valid = w_head_entry.slot_valid;
    end else begin
      o_out_slot_valid = {FETCH_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed + randomized bench for fetch_queue, checked against
// a packet-queue reference model.
module tb_fetch_queue;

  localparam int FW = 4;
  localparam int D  = 8;
  localparam int EW = 5;

  typedef struct packed {
    logic [FW-1:0]         sv;
    logic [FW-1:0][31:0]   pc;
    logic [FW-1:0]         hit;
    logic [FW-1:0]         pred;
    logic [FW-1:0][31:0]   tgt;
    logic [FW-1:0]         he;
    logic [FW-1:0][EW-1:0] ec;
  } pkt_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  flush = 1'b0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [FW-1:0]         in_sv = '0;
  logic [FW-1:0][31:0]   in_pc = '0;
  logic [FW-1:0]         in_hit = '0;
  logic [FW-1:0]         in_pred = '0;
  logic [FW-1:0][31:0]   in_tgt = '0;
  logic [FW-1:0]         in_he = '0;
  logic [FW-1:0][EW-1:0] in_ec = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic [FW-1:0]         out_sv;
  logic [FW-1:0][31:0]   out_pc;
  logic [FW-1:0]         out_hit;
  logic [FW-1:0]         out_pred;
  logic [FW-1:0][31:0]   out_tgt;
  logic [FW-1:0]         out_he;
  logic [FW-1:0][EW-1:0] out_ec;
  logic [3:0]            count;

  int   tests = 0;
  int   fails = 0;
  pkt_t mq[$];

  fetch_queue #(.FETCH_W(FW), .DEPTH(D), .EXCP_W(EW)) dut (
    .clk(clk), .rst(rst), .i_flush(flush),
    .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_slot_valid(in_sv), .i_in_pc(in_pc), .i_in_hit(in_hit),
    .i_in_predict(in_pred), .i_in_target(in_tgt), .i_in_has_excp(in_he),
    .i_in_excp_code(in_ec),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_slot_valid(out_sv), .o_out_pc(out_pc), .o_out_hit(out_hit),
    .o_out_predict(out_pred), .o_out_target(out_tgt), .o_out_has_excp(out_he),
    .o_out_excp_code(out_ec), .o_count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic pkt_t rand_pkt();
    pkt_t p;
    p.sv   = 4'($urandom);
    p.hit  = 4'($urandom);
    p.pred = 4'($urandom);
    p.he   = 4'($urandom);
    for (int s = 0; s < FW; s++) begin
      p.pc[s]  = $urandom & 32'hFFFF_FFFC;
      p.tgt[s] = $urandom & 32'hFFFF_FFFC;
      p.ec[s]  = 5'($urandom);
    end
    return p;
  endfunction

  function automatic pkt_t seq_pkt(input int i);
    pkt_t p;
    p = '0;
    p.sv = 4'b1111;
    for (int s = 0; s < FW; s++) p.pc[s] = 32'h1c00_0000 + 32'(4 * i) + 32'(16 * s);
    p.tgt[0] = 32'(i);
    return p;
  endfunction

  task automatic drive(input pkt_t p);
    in_sv = p.sv; in_pc = p.pc; in_hit = p.hit; in_pred = p.pred;
    in_tgt = p.tgt; in_he = p.he; in_ec = p.ec;
  endtask

  // Compare every DUT output against the reference queue.
  task automatic check_model(input string tag);
    pkt_t h;
    chk({tag, ".count"}, 160'(count), 160'(mq.size()));
    chk({tag, ".in_ready"}, 160'(in_ready), 160'(mq.size() != D));
    chk({tag, ".out_valid"}, 160'(out_valid), 160'(mq.size() != 0));
    if (mq.size() != 0) begin
      h = mq[0];
      chk({tag, ".slot_valid"}, 160'(out_sv), 160'(h.sv));
      chk({tag, ".pc"}, 160'(out_pc), 160'(h.pc));
      chk({tag, ".hit"}, 160'(out_hit), 160'(h.hit));
      chk({tag, ".predict"}, 160'(out_pred), 160'(h.pred));
      chk({tag, ".target"}, 160'(out_tgt), 160'(h.tgt));
      chk({tag, ".has_excp"}, 160'(out_he), 160'(h.he));
      chk({tag, ".excp_code"}, 160'(out_ec), 160'(h.ec));
    end else begin
      chk({tag, ".slot_valid0"}, 160'(out_sv), 160'(0));
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".count"}, 160'(count), 160'(0));
    chk({tag, ".in_ready"}, 160'(in_ready), 160'(1));
    chk({tag, ".out_valid"}, 160'(out_valid), 160'(0));
    chk({tag, ".slot_valid"}, 160'(out_sv), 160'(0));
    chk({tag, ".pc"}, 160'(out_pc), 160'(0));
    chk({tag, ".target"}, 160'(out_tgt), 160'(0));
    chk({tag, ".sideband"}, 160'({out_hit, out_pred, out_he, out_ec}), 160'(0));
  endtask

  // One clock edge: apply the queue rules to the model, then check outputs.
  task automatic cycle(input string tag);
    pkt_t p;
    bit   push;
    bit   pop;
    p = '{sv: in_sv, pc: in_pc, hit: in_hit, pred: in_pred, tgt: in_tgt, he: in_he, ec: in_ec};
    push = in_valid && (mq.size() < D) && (p.sv != 4'b0000);
    pop  = out_ready && (mq.size() > 0);
    @(posedge clk);
    #1;
    if (flush) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(p);
    end
    check_model(tag);
  endtask

  initial begin
    pkt_t p;
    // Reset state
    #12;
    check_reset_vals("reset");
    rst = 1'b1;

    // First push appears one cycle later
    drive(seq_pkt(0)); in_valid = 1'b1; out_ready = 1'b0;
    cycle("first_push");
    chk("first_pc0", 160'(out_pc[0]), 160'(32'h1c00_0000));
    chk("first_count", 160'(count), 160'(1));

    // Fill to full, then an ignored 9th push
    for (int i = 1; i < D; i++) begin
      drive(seq_pkt(i));
      cycle("fill");
    end
    chk("full_count", 160'(count), 160'(8));
    chk("full_in_ready", 160'(in_ready), 160'(0));
    drive(seq_pkt(99));
    cycle("ninth_push");
    chk("ninth_count", 160'(count), 160'(8));

    // Drain in order
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < D; i++) begin
      chk("drain_pc0", 160'(out_pc[0]), 160'(32'h1c00_0000 + 32'(4 * i)));
      cycle("drain");
    end
    chk("empty_out_valid", 160'(out_valid), 160'(0));

    // Preload 3, then 20 cycles of simultaneous push+pop
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      p = rand_pkt(); p.sv[0] = 1'b1; drive(p);
      cycle("preload3");
    end
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      p = rand_pkt(); p.sv[2] = 1'b1; drive(p);
      cycle("steady");
      chk("steady_count", 160'(count), 160'(3));
    end

    // Zero-mask packet is dropped; partial mask keeps sideband
    out_ready = 1'b0;
    p = rand_pkt(); p.sv = 4'b0000; drive(p);
    chk("zero_mask_ready", 160'(in_ready), 160'(1));
    cycle("zero_mask");
    chk("zero_mask_count", 160'(count), 160'(3));
    flush = 1'b1; in_valid = 1'b0;
    cycle("flush_pre");
    flush = 1'b0; in_valid = 1'b1;
    p = rand_pkt(); p.sv = 4'b0011; p.he = 4'b0010; p.ec = '0; p.ec[1] = 5'h08; drive(p);
    cycle("partial_mask");
    chk("partial_sv", 160'(out_sv), 160'(4'b0011));
    chk("partial_ec1", 160'(out_ec[1]), 160'(5'h08));
    chk("partial_he", 160'(out_he), 160'(4'b0010));

    // Flush at count 5 together with push and pop
    for (int i = 0; i < 4; i++) begin
      p = rand_pkt(); p.sv[3] = 1'b1; drive(p);
      cycle("to_five");
    end
    chk("five_count", 160'(count), 160'(5));
    flush = 1'b1; out_ready = 1'b1;
    cycle("flush");
    flush = 1'b0;
    check_reset_vals_partial: begin
      chk("flush_count", 160'(count), 160'(0));
      chk("flush_out_valid", 160'(out_valid), 160'(0));
      chk("flush_slot_valid", 160'(out_sv), 160'(0));
      chk("flush_in_ready", 160'(in_ready), 160'(1));
    end

    // Asynchronous reset mid-cycle at count 4
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      p = rand_pkt(); p.sv[1] = 1'b1; drive(p);
      cycle("to_four");
    end
    chk("four_count", 160'(count), 160'(4));
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    mq.delete();
    check_reset_vals("async_rst");
    #2 rst = 1'b1;
    in_valid = 1'b1;
    p = seq_pkt(7); drive(p);
    cycle("post_rst_push");
    chk("post_rst_pc0", 160'(out_pc[0]), 160'(32'h1c00_001c));

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(rand_pkt());
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      cycle("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised fetch-packet queue between the instruction-fetch stage and decode. Buffers up to DEPTH fetch packets of FETCH_W slots each, carrying per-slot PC, branch-prediction and exception sideband. It replaces a single-entry fetch pipeline register with a valid/ready FIFO, so fetch keeps running while decode stalls. Flush support discards all buffered packets on redirect.

## Interface
- FETCH_W, 4, slots per fetch packet (≥1)
- DEPTH, 8, packet entries; power of two, ≥2
- EXCP_W, 5, exception code width
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- flush  in  1  discard all entries, synchronous
- in_valid  in  1  fetch presents a packet
- in_ready  out  1  queue can accept a packet
- in_slot_valid  in  FETCH_W  per-slot valid mask
- in_pc  in  32 x [FETCH_W]  slot PCs
- in_hit, in_predict  in  1 x [FETCH_W]  BTB hit, predicted taken
- in_target  in  32 x [FETCH_W]  predicted target
- in_has_excp  in  1 x [FETCH_W]  fetch exception flag
- in_excp_code  in  EXCP_W x [FETCH_W]  exception code
- out_valid  out  1  head packet available
- out_ready  in  1  decode accepts head packet
- out_slot_valid, out_pc, out_hit, out_predict, out_target, out_has_excp, out_excp_code  out  as inputs  head packet fields
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Storage: DEPTH entries of the full packet record; head/tail pointers $clog2(DEPTH) bits, wrap modulo DEPTH; count register tracks occupancy 0..DEPTH.
- push = in_valid & in_ready & (|in_slot_valid). A packet with all-zero slot mask is accepted (handshake completes) but not written; count unchanged.
- pop = out_valid & out_ready.
- in_ready = (count != DEPTH); depends only on registered state, never on out_ready (no same-cycle pass-through at full).
- out_valid = (count != 0). Out fields are read from entry[head]; when out_valid=0, out_slot_valid is forced to 0 and other out fields are don't-care.
- Push and pop in the same cycle: both take effect, count unchanged; legal at any non-full, non-empty occupancy, and at full only if in_ready was 1 (i.e. never at full).
- Empty queue: no bypass; a pushed packet appears at outputs the following cycle.
- flush: head, tail, count ← 0 next edge; push and pop in that cycle are ignored. Flush has priority over everything.
- Reset: pointers, count, and all storage ← 0.

## Timing
- Latency in→out: 1 cycle (push at edge N, out_valid at N+1).
- Throughput: one packet per cycle in and out sustained when 0<count<DEPTH.
- Reset values: in_ready=1, out_valid=0, count=0, out_slot_valid=0, all other outputs 0.
- After flush edge: out_valid=0, in_ready=1, count=0 in the following cycle.
- Reset asserted mid-operation clears state immediately (asynchronous); no packet survives.
- Pointer wrap: tail/head DEPTH-1 → 0 without bubble.

## Test plan
- Reset, then push packet {pc=0x1c000000+4i, slot_valid=4'b1111} with out_ready=0 → next cycle out_valid=1, out_pc[0]=0x1c000000, count=1.
- Push 8 packets with out_ready=0 (DEPTH=8) → count=8, in_ready=0; 9th in_valid ignored; then pop 8 → packets returned in order, count=0, out_valid=0.
- Steady push+pop every cycle for 20 cycles from count=3 → count stays 3, outputs in order, pointers wrap cleanly.
- Push with in_slot_valid=4'b0000 → in_ready handshake completes, count unchanged; slot_valid=4'b0011 → stored mask 0011, out_has_excp/out_excp_code preserved (e.g. excp_code=5'h08 on slot 1).
- count=5, flush asserted together with push and pop → next cycle count=0, out_valid=0, out_slot_valid=0, in_ready=1.
- Drop rst asynchronously between edges at count=4 → outputs at reset values immediately; first push after release appears one cycle later.
